// File: rtl/spi_req_arbiter_if.sv
// Bundles the requester-side and SPI-master-side signals of spi_req_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    // Handshake: req[i] is a level held with req_data until gnt[i] pulses for one
    // cycle; rsp_valid[i] is a one-cycle pulse carrying rsp_data/rsp_err, and there
    // is no ready/back-pressure on either direction. m_start is a one-cycle pulse
    // and m_done a one-cycle pulse that qualifies m_rx_data.
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic                      busy;
    logic                      m_start;
    logic [DATA_W-1:0]         m_tx_data;
    logic [DATA_W-1:0]         m_rx_data;
    logic                      m_done;
    logic                      m_cs_n;
    logic [NUM_REQ-1:0]        cs_n_out;
    logic [1:0]                dbg_state;

    modport master (
        input  req, req_data, m_rx_data, m_done, m_cs_n,
        output gnt, rsp_valid, rsp_data, rsp_err, busy,
               m_start, m_tx_data, cs_n_out, dbg_state
    );

    modport slave (
        output req, req_data, m_rx_data, m_done, m_cs_n,
        input  gnt, rsp_valid, rsp_data, rsp_err, busy,
               m_start, m_tx_data, cs_n_out, dbg_state
    );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters, with
// chip-select routing to the owner and a watchdog that aborts stuck transfers.
module spi_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    spi_req_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [IW-1:0]     owner;
    logic [IW-1:0]     rr_ptr;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     scan_idx;
    logic              found;
    logic [DATA_W-1:0] win_data;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              err_q;
    logic              routing;
    logic              timed_out;

    // Scan from the round-robin pointer upward, wrapping, and take the first set request.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
            scan_idx = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == winner) begin
                win_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timed_out = (cnt == CNT_LAST);

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (found) state_d = START;
            START:   state_d = BUSY;
            BUSY:    if (bus.m_done || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (found) begin
                        owner  <= winner;
                        tx_q   <= win_data;
                        rr_ptr <= (winner == IDX_LAST) ? '0 : winner + 1'b1;
                    end
                end
                START: cnt <= '0;
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // A done arriving on the terminal-count cycle still counts as success.
                    if (bus.m_done) begin
                        rx_q  <= bus.m_rx_data;
                        err_q <= 1'b0;
                    end else if (timed_out) begin
                        rx_q  <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign routing = (state == START) || (state == BUSY);

    always_comb begin
        bus.gnt       = '0;
        bus.rsp_valid = '0;
        bus.cs_n_out  = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == owner) begin
                bus.gnt[i]       = (state == START);
                bus.rsp_valid[i] = (state == RESP);
                bus.cs_n_out[i]  = routing ? bus.m_cs_n : 1'b1;
            end
        end
    end

    assign bus.rsp_data  = (state == RESP) ? rx_q : '0;
    assign bus.rsp_err   = (state == RESP) ? err_q : 1'b0;
    assign bus.busy      = (state != IDLE);
    assign bus.m_start   = (state == START);
    assign bus.m_tx_data = tx_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: the bench plays the SPI master and the requesters and
// predicts grants, chip-selects and responses from round-robin rules.
module tb_spi_req_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    logic [8:0] exp_q[$];

    spi_req_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    spi_req_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench watchdog expired");
    end

    function automatic int rr_pick(int ptr, logic [3:0] r);
        int idx;
        for (int k = 0; k < NR; k++) begin
            idx = (ptr + k) % NR;
            if (r[idx[1:0]]) return idx;
        end
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.m_done = 1'b0;
        bus.m_cs_n = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++; if (bus.gnt !== 4'b0) begin errors++; $display("FAIL %s gnt: got %b exp 0000", tag, bus.gnt); end
        checks++; if (bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL %s rsp_valid: got %b exp 0000", tag, bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL %s rsp: got %h/%b exp 00/0", tag, bus.rsp_data, bus.rsp_err); end
        checks++; if (bus.busy !== 1'b0 || bus.m_start !== 1'b0) begin errors++; $display("FAIL %s busy/start: got %b/%b exp 0/0", tag, bus.busy, bus.m_start); end
        checks++; if (bus.m_tx_data !== 8'h00) begin errors++; $display("FAIL %s m_tx_data: got %h exp 00", tag, bus.m_tx_data); end
        checks++; if (bus.cs_n_out !== 4'hf) begin errors++; $display("FAIL %s cs_n_out: got %b exp 1111", tag, bus.cs_n_out); end
    endtask

    // One arbitration + transfer. lat=0 means the master never signals done.
    task automatic run_txn(input logic [3:0] reqv, input logic [31:0] data, input int lat,
                           input logic [7:0] rx, input int exp_win, input string tag);
        int win;
        logic [3:0] oh;
        logic [31:0] sh;
        logic [7:0] exp_tx;
        logic [8:0] exp;
        win = (exp_win >= 0) ? exp_win : rr_pick(model_ptr, reqv);
        oh = 4'b0001 << win;
        sh = data >> (win * 8);
        exp_tx = sh[7:0];
        model_ptr = (win + 1) % NR;
        bus.req = reqv;
        bus.req_data = data;
        @(posedge clk); #1;
        checks++; if (bus.gnt !== oh) begin errors++; $display("FAIL %s gnt: got %b exp %b", tag, bus.gnt, oh); end
        checks++; if (bus.m_start !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL %s start/busy: got %b/%b exp 1/1", tag, bus.m_start, bus.busy); end
        checks++; if (bus.m_tx_data !== exp_tx) begin errors++; $display("FAIL %s m_tx_data: got %h exp %h", tag, bus.m_tx_data, exp_tx); end
        checks++; if (bus.cs_n_out !== 4'hf) begin errors++; $display("FAIL %s cs_idle: got %b exp 1111", tag, bus.cs_n_out); end
        bus.m_cs_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.gnt !== 4'b0 || bus.m_start !== 1'b0) begin errors++; $display("FAIL %s pulse_width: got gnt %b start %b exp 0000/0", tag, bus.gnt, bus.m_start); end
        checks++; if (bus.cs_n_out !== ~oh) begin errors++; $display("FAIL %s cs_route: got %b exp %b", tag, bus.cs_n_out, ~oh); end
        if (lat > 0) begin
            for (int k = 1; k < lat; k++) begin
                @(posedge clk); #1;
                checks++; if (bus.rsp_valid !== 4'b0 || bus.cs_n_out !== ~oh) begin errors++; $display("FAIL %s busy_wait: got rsp %b cs %b exp 0000/%b", tag, bus.rsp_valid, bus.cs_n_out, ~oh); end
            end
            bus.m_done = 1'b1;
            bus.m_rx_data = rx;
            exp_q.push_back({1'b0, rx});
            @(posedge clk); #1;
            bus.m_done = 1'b0;
            bus.m_rx_data = 8'($urandom);
        end else begin
            exp_q.push_back(9'h100);
            for (int k = 1; k < TO; k++) begin
                @(posedge clk); #1;
                checks++; if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL %s timeout_wait: got rsp %b busy %b exp 0000/1", tag, bus.rsp_valid, bus.busy); end
            end
            @(posedge clk); #1;
        end
        bus.m_cs_n = 1'b1;
        exp = exp_q.pop_front();
        checks++; if (bus.rsp_valid !== oh) begin errors++; $display("FAIL %s rsp_valid: got %b exp %b", tag, bus.rsp_valid, oh); end
        checks++; if (bus.rsp_data !== exp[7:0] || bus.rsp_err !== exp[8]) begin errors++; $display("FAIL %s rsp: got %h/%b exp %h/%b", tag, bus.rsp_data, bus.rsp_err, exp[7:0], exp[8]); end
        checks++; if (bus.busy !== 1'b1 || bus.cs_n_out !== 4'hf) begin errors++; $display("FAIL %s resp_state: got busy %b cs %b exp 1/1111", tag, bus.busy, bus.cs_n_out); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL %s back_idle: got rsp %b busy %b exp 0000/0", tag, bus.rsp_valid, bus.busy); end
        checks++; if (bus.rsp_data !== 8'h00 || bus.rsp_err !== 1'b0) begin errors++; $display("FAIL %s rsp_clear: got %h/%b exp 00/0", tag, bus.rsp_data, bus.rsp_err); end
    endtask

    task automatic test_reset();
        bus.req_data = '0;
        bus.m_rx_data = '0;
        do_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_single();
        run_txn(4'b0010, 32'h0000_A500, 5, 8'h3C, 1, "single");
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int n = 0; n < 6; n++)
            run_txn(4'b1111, 32'h44332211, $urandom_range(1, 14), 8'($urandom), n % NR, "round_robin");
    endtask

    task automatic test_no_starve();
        do_reset();
        run_txn(4'b0001, 32'h000000AA, 2, 8'h11, 0, "starve_setup");
        for (int n = 0; n < 4; n++)
            run_txn(4'b0101, 32'h00CC00DD, $urandom_range(1, 6), 8'($urandom), (n % 2 == 0) ? 2 : 0, "no_starve");
    endtask

    task automatic test_timeout();
        run_txn(4'b0100, 32'h00770000, 0, 8'hEE, -1, "timeout");
        run_txn(4'b0100, 32'h00780000, 3, 8'h3C, -1, "after_timeout");
    endtask

    task automatic test_done_at_terminal();
        run_txn(4'b1000, 32'h5A000000, TO, 8'h96, -1, "terminal_tie");
    endtask

    task automatic test_idle_ignores_done();
        bus.req = '0;
        bus.m_done = 1'b1;
        bus.m_rx_data = 8'hFF;
        @(posedge clk); #1;
        bus.m_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 4'b0) begin errors++; $display("FAIL idle_done: got busy %b rsp %b exp 0/0000", bus.busy, bus.rsp_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_busy();
        bus.req = 4'b1000;
        bus.req_data = 32'h9B000000;
        @(posedge clk); #1;
        bus.m_cs_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        bus.req = '0;
        bus.m_cs_n = 1'b1;
        bus.m_done = 1'b1;
        bus.m_rx_data = 8'h42;
        model_ptr = 0;
        @(posedge clk); #1;
        bus.m_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.rsp_valid !== 4'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dropped_rsp: got rsp %b busy %b exp 0000/0", bus.rsp_valid, bus.busy); end
            @(posedge clk); #1;
        end
        run_txn(4'b1000, 32'hC3000000, 4, 8'h3C, 3, "after_reset");
    endtask

    task automatic test_random();
        logic [3:0] r;
        for (int n = 0; n < 24; n++) begin
            r = 4'($urandom_range(1, 15));
            run_txn(r, $urandom, ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TO),
                    8'($urandom), -1, "random");
        end
    endtask

    initial begin
        bus.req = '0;
        bus.req_data = '0;
        bus.m_rx_data = '0;
        bus.m_done = 1'b0;
        bus.m_cs_n = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_no_starve();
        test_timeout();
        test_done_at_terminal();
        test_idle_ignores_done();
        test_reset_mid_busy();
        test_random();
        bus.req = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
